fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the ARM single-cycle core.
// Owns the PC, fetches one instruction per req/ready + rvalid handshake,
// holds it for decode/control, and advances the PC when execute completes.
// Optional build macro: FETCH_PERF_CNT_EN adds the perf_retired/perf_stall counters.
module fetch_unit #(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    input  logic              ex_done,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] result
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EXEC = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP4 = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_STEP8 = ADDR_W'(8);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;

    // Branch targets are word-aligned by dropping the low two bits.
    logic [1:0] unused_result_lsb;
    assign unused_result_lsb = result[1:0];

    // State, PC and instruction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Fetch sequencing: request, wait for data, hold while executing, advance PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        state_d = EXEC;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ex_done) begin
                    pc_d    = pcsrc ? {result[ADDR_W-1:2], 2'b00} : pc_q + PC_STEP4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign pc          = pc_q;
    assign pc_plus8    = pc_q + PC_STEP8;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_q, stall_q;

    // Retired-instruction and fetch-stall counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == EXEC && ex_done) begin
                retired_q <= retired_q + 32'd1;
            end
            if (state_q == REQ || state_q == WAIT) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_retired = retired_q;
    assign perf_stall   = stall_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// The stimulus process plays memory and execute stage and pushes the expected
// (pc, instruction) for every fetch; a monitor pops and compares on each new
// instr_valid. The reference model is the architectural PC sequence.
module tb_fetch_unit;

    localparam int unsigned AW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        ex_done;
    logic        pcsrc;
    logic [31:0] result;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W  (AW),
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus8   (pc_plus8),
        .ex_done    (ex_done),
        .pcsrc      (pcsrc),
        .result     (result)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_retired(perf_retired),
        .perf_stall  (perf_stall)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] model_pc;
    logic [31:0] model_retired;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each newly presented instruction against the scoreboard.
    logic        mon_prev;
    logic [31:0] mon_instr;
    initial begin
        exp_t e;
        mon_prev  = 1'b0;
        mon_instr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev = 1'b0;
            end else begin
                if (instr_valid && !mon_prev) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_instr", instr_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("mon_instr", instr, e.instr);
                        chk("mon_pc", pc, e.pc);
                        chk("mon_pc_plus8", pc_plus8, e.pc + 32'd8);
                        mon_instr = e.instr;
                    end
                end else if (instr_valid) begin
                    chk("mon_instr_hold", instr, mon_instr);
                end
                mon_prev = instr_valid;
            end
        end
    end

    task automatic noise();
        imem_rdata = $urandom;
        pcsrc      = 1'($urandom);
        result     = $urandom;
        ex_done    = 1'($urandom);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_valid"}, instr_valid, 1'b0);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_instr"}, instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_perf_ret"}, perf_retired, 32'h0);
        chk({tag, "_perf_stall"}, perf_stall, 32'h0);
`endif
    endtask

    // Keep reset high for two cycles, then release on a negedge.
    task automatic hold_reset();
        repeat (2) @(negedge clk);
        sb.delete();
        model_pc      = RST_PC;
        model_retired = '0;
        reset         = 1'b0;
    endtask

    task automatic do_fetch(input int unsigned rdy_dly, input int unsigned rv_dly,
                            input logic [31:0] data, output int unsigned waited);
        int unsigned n = 0;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] st0 = perf_stall;
`endif
        while (!imem_req && n < 16) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'b0;
            noise();
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!imem_req) begin
            chk("req_timeout", imem_req, 1'b1);
            return;
        end
        chk("fetch_addr", imem_addr, model_pc);
        chk("fetch_valid_low", instr_valid, 1'b0);
        for (int unsigned i = 0; i < rdy_dly; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'b0;
            noise();
            @(negedge clk);
            chk("req_held", imem_req, 1'b1);
        end
        imem_ready  = 1'b1;
        imem_rvalid = (rv_dly == 0);
        noise();
        imem_rdata  = data;
        sb.push_back('{pc: model_pc, instr: data});
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        noise();
        if (rv_dly == 0) ex_done = 1'b0;
        chk("req_drop", imem_req, 1'b0);
        if (rv_dly > 0) begin
            for (int unsigned i = 1; i < rv_dly; i++) begin
                chk("wait_valid_low", instr_valid, 1'b0);
                imem_ready = 1'($urandom);
                @(negedge clk);
                noise();
            end
            imem_rvalid = 1'b1;
            imem_ready  = 1'($urandom);
            imem_rdata  = data;
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_ready  = 1'b0;
        end
        ex_done = 1'b0;
        pcsrc   = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_delta", perf_stall - st0, rdy_dly + 1 + rv_dly);
`endif
    endtask

    task automatic do_exec(input int unsigned hold, input logic src, input logic [31:0] res);
        int unsigned n = 0;
        while (!instr_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            chk("exec_timeout", instr_valid, 1'b1);
            return;
        end
        chk("exec_pc", pc, model_pc);
        chk("exec_pc_plus8", pc_plus8, model_pc + 32'd8);
        for (int unsigned i = 0; i < hold; i++) begin
            ex_done     = 1'b0;
            pcsrc       = 1'($urandom);
            result      = $urandom;
            imem_rvalid = 1'($urandom);
            imem_ready  = 1'($urandom);
            imem_rdata  = $urandom;
            @(negedge clk);
            chk("exec_pc_stable", pc, model_pc);
            chk("exec_valid_held", instr_valid, 1'b1);
        end
        ex_done     = 1'b1;
        pcsrc       = src;
        result      = res;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        @(negedge clk);
        ex_done = 1'b0;
        pcsrc   = 1'b0;
        model_pc      = src ? {res[31:2], 2'b00} : model_pc + 32'd4;
        model_retired = model_retired + 32'd1;
        chk("next_pc", pc, model_pc);
        chk("next_valid_low", instr_valid, 1'b0);
        chk("next_req", imem_req, 1'b1);
        chk("next_addr", imem_addr, model_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_retired", perf_retired, model_retired);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        ex_done     = 1'b0;
        pcsrc       = 1'b0;
        result      = '0;
        model_pc      = RST_PC;
        model_retired = '0;
        @(negedge clk);
        chk_reset_vals("por");
        hold_reset();
        chk("idle_req", imem_req, 1'b0);

        // First fetch: single-cycle accept+data, EXEC two cycles after IDLE.
        do_fetch(0, 0, 32'hE3A0_1005, w);
        chk("first_wait_cycles", w, 1);
        chk("first_valid", instr_valid, 1'b1);
        chk("first_instr", instr, 32'hE3A0_1005);
        do_exec(1, 1'b0, 32'h0);                        // pc -> 4
        do_fetch(2, 0, $urandom, w);
        do_exec(0, 1'b1, 32'h0000_0102);                // pc -> 0x100
        do_fetch(3, 2, $urandom, w);                    // 4 REQ + 2 WAIT cycles
        do_exec(2, 1'b1, 32'hFFFF_FFFE);                // pc -> FFFF_FFFC
        do_fetch(1, 1, $urandom, w);
        do_exec(0, 1'b0, 32'h0);                        // pc wraps to 0
        do_fetch(0, 3, $urandom, w);
        do_exec(0, 1'b0, 32'h0);                        // pc -> 4

        // Reset while waiting for read data, then a stale rvalid after release.
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_wait");
        hold_reset();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stale_idle_valid", instr_valid, 1'b0);
        chk("stale_idle_instr", instr, 32'h0);
        @(negedge clk);
        chk("stale_req_valid", instr_valid, 1'b0);
        chk("stale_req_instr", instr, 32'h0);
        imem_rvalid = 1'b0;
        do_fetch(0, 1, 32'h1234_5678, w);
        do_exec(1, 1'b0, 32'h0);
        do_fetch(0, 0, $urandom, w);

        // Reset in EXEC.
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_exec");
        hold_reset();

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, w);
            do_exec($urandom_range(0, 3), 1'($urandom), $urandom);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
